// File: rtl/sprite_sched_pkg.sv
// Shared types for the sprite line scheduler.
//   state_t      : scan sequencer states
//   span_t       : one horizontal span latched for the upcoming line
//   eval_span()  : turns a returned descriptor into a span for a given line
package sprite_sched_pkg;

    localparam int unsigned NUM_SPR_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        LAST = 2'd2
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [10:0] x_start;
        logic [10:0] x_end;    // exclusive
        int          color;
    } span_t;

    // 11-bit sums keep y+h and x+w from wrapping past the 10-bit screen range.
    function automatic span_t eval_span(
        input logic [9:0] scan_y,
        input logic       en,
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [9:0] w,
        input logic [9:0] h,
        input int         color
    );
        span_t       s;
        logic [10:0] y_end;
        y_end     = {1'b0, y} + {1'b0, h};
        s.valid   = en && (w != '0) && (h != '0) &&
                    ({1'b0, scan_y} >= {1'b0, y}) && ({1'b0, scan_y} < y_end);
        s.x_start = {1'b0, x};
        s.x_end   = {1'b0, x} + {1'b0, w};
        s.color   = color;
        return s;
    endfunction

endpackage

// File: rtl/span_priority_sel.sv
// Combinational span hit test with lowest-index priority.
//   DrawX     : current pixel column
//   spans     : active spans, index 0 has highest priority
//   hit       : some valid span covers DrawX
//   win_color : color of the winning span (0 when no hit)
module span_priority_sel
    import sprite_sched_pkg::*;
#(
    parameter int unsigned NUM_SPR = NUM_SPR_DEFAULT
) (
    input  logic [9:0]                DrawX,
    input  span_t [NUM_SPR-1:0]       spans,
    output logic                      hit,
    output logic [31:0]               win_color
);

    always_comb begin
        hit       = 1'b0;
        win_color = '0;
        for (int unsigned i = 0; i < NUM_SPR; i++) begin
            if (!hit && spans[i].valid &&
                ({1'b0, DrawX} >= spans[i].x_start) &&
                ({1'b0, DrawX} <  spans[i].x_end)) begin
                hit       = 1'b1;
                win_color = spans[i].color;
            end
        end
    end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler.
//   Clk, Reset          : clock, synchronous active-high reset
//   line_start, next_y  : start-of-hblank pulse and the line about to be drawn
//   DrawX               : current pixel column
//   spr_req, spr_idx    : descriptor read strobe and slot index
//   spr_en..spr_color   : descriptor return, one cycle after spr_req
//   color               : registered palette index for DrawX of the previous edge
//   busy                : scan in progress
//   overrun             : sticky, line_start seen during a scan
module sprite_line_scheduler
    import sprite_sched_pkg::*;
#(
    parameter int unsigned NUM_SPR  = NUM_SPR_DEFAULT,
    parameter int          BG_COLOR = 0
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       line_start,
    input  logic [9:0]                 next_y,
    input  logic [9:0]                 DrawX,
    output logic                       spr_req,
    output logic [$clog2(NUM_SPR)-1:0] spr_idx,
    input  logic                       spr_en,
    input  logic [9:0]                 spr_x,
    input  logic [9:0]                 spr_y,
    input  logic [9:0]                 spr_w,
    input  logic [9:0]                 spr_h,
    input  logic [31:0]                spr_color,
    output logic [31:0]                color,
    output logic                       busy,
    output logic                       overrun
);

    localparam int unsigned IDX_W = $clog2(NUM_SPR);

    state_t               state_q,   state_d;
    logic                 spr_req_q, spr_req_d;
    logic [IDX_W-1:0]     spr_idx_q, spr_idx_d;
    logic [9:0]           scan_y_q,  scan_y_d;
    logic                 overrun_q, overrun_d;
    logic [31:0]          color_q,   color_d;
    span_t [NUM_SPR-1:0]  shadow_q,  shadow_d;
    span_t [NUM_SPR-1:0]  active_q,  active_d;

    span_t                ret_span;
    logic                 hit;
    logic [31:0]          win_color;

    always_comb begin
        ret_span = eval_span(scan_y_q, spr_en, spr_x, spr_y, spr_w, spr_h, spr_color);
    end

    always_comb begin
        state_d   = state_q;
        spr_req_d = spr_req_q;
        spr_idx_d = spr_idx_q;
        scan_y_d  = scan_y_q;
        overrun_d = overrun_q;
        shadow_d  = shadow_q;
        active_d  = active_q;

        unique case (state_q)
            IDLE: begin
                if (line_start) begin
                    state_d   = SCAN;
                    scan_y_d  = next_y;
                    spr_req_d = 1'b1;
                    spr_idx_d = '0;
                end
            end
            SCAN: begin
                // The return on the bus belongs to the index issued last cycle.
                if (spr_idx_q != '0) begin
                    shadow_d[spr_idx_q - 1'b1] = ret_span;
                end
                if (spr_idx_q == IDX_W'(NUM_SPR - 1)) begin
                    state_d   = LAST;
                    spr_req_d = 1'b0;
                end else begin
                    spr_idx_d = spr_idx_q + 1'b1;
                end
            end
            LAST: begin
                shadow_d[NUM_SPR-1] = ret_span;
                active_d  = shadow_d;
                state_d   = IDLE;
                spr_idx_d = '0;
            end
            default: state_d = IDLE;
        endcase

        // A new line during a scan abandons it; the committed spans stay put.
        if (line_start && (state_q != IDLE)) begin
            overrun_d = 1'b1;
            shadow_d  = '0;
            active_d  = active_q;
            state_d   = SCAN;
            scan_y_d  = next_y;
            spr_req_d = 1'b1;
            spr_idx_d = '0;
        end
    end

    span_priority_sel #(
        .NUM_SPR (NUM_SPR)
    ) u_sel (
        .DrawX     (DrawX),
        .spans     (active_q),
        .hit       (hit),
        .win_color (win_color)
    );

    always_comb begin
        color_d = hit ? win_color : BG_COLOR;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            spr_req_q <= 1'b0;
            spr_idx_q <= '0;
            scan_y_q  <= '0;
            overrun_q <= 1'b0;
            color_q   <= BG_COLOR;
            shadow_q  <= '0;
            active_q  <= '0;
        end else begin
            state_q   <= state_d;
            spr_req_q <= spr_req_d;
            spr_idx_q <= spr_idx_d;
            scan_y_q  <= scan_y_d;
            overrun_q <= overrun_d;
            color_q   <= color_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
        end
    end

    assign spr_req = spr_req_q;
    assign spr_idx = spr_idx_q;
    assign color   = color_q;
    assign busy    = (state_q != IDLE);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
module tb_sprite_line_scheduler;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        line_start;
    logic [9:0]  next_y;
    logic [9:0]  DrawX;
    logic        spr_req;
    logic [2:0]  spr_idx;
    logic        spr_en;
    logic [9:0]  spr_x, spr_y, spr_w, spr_h;
    logic [31:0] spr_color;
    logic [31:0] color;
    logic        busy;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    // descriptor table
    logic        t_en [8];
    logic [9:0]  t_x  [8];
    logic [9:0]  t_y  [8];
    logic [9:0]  t_w  [8];
    logic [9:0]  t_h  [8];
    logic [31:0] t_c  [8];

    sprite_line_scheduler #(
        .NUM_SPR  (8),
        .BG_COLOR (0)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .line_start (line_start),
        .next_y     (next_y),
        .DrawX      (DrawX),
        .spr_req    (spr_req),
        .spr_idx    (spr_idx),
        .spr_en     (spr_en),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .spr_w      (spr_w),
        .spr_h      (spr_h),
        .spr_color  (spr_color),
        .color      (color),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 Clk = ~Clk;

    // one-cycle-latency descriptor memory
    always @(posedge Clk) begin
        if (spr_req) begin
            spr_en    <= t_en[spr_idx];
            spr_x     <= t_x[spr_idx];
            spr_y     <= t_y[spr_idx];
            spr_w     <= t_w[spr_idx];
            spr_h     <= t_h[spr_idx];
            spr_color <= t_c[spr_idx];
        end else begin
            spr_en    <= 1'b0;
        end
    end

    task automatic set_slot(input int i, input logic en, input logic [9:0] x, input logic [9:0] y,
                            input logic [9:0] w, input logic [9:0] h, input logic [31:0] c);
        t_en[i] = en; t_x[i] = x; t_y[i] = y; t_w[i] = w; t_h[i] = h; t_c[i] = c;
    endtask

    task automatic do_scan(input logic [9:0] y);
        line_start = 1'b1;
        next_y     = y;
        @(posedge Clk); #1;
        line_start = 1'b0;
        repeat (9) @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; line_start = 1'b0; next_y = '0; DrawX = '0;
        repeat (2) @(posedge Clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d exp=0", busy); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%0d exp=0", overrun); end
        total++; if (spr_req !== 1'b0) begin bad++; $display("FAIL reset_spr_req got=%0d exp=0", spr_req); end
        total++; if (spr_idx !== 3'd0) begin bad++; $display("FAIL reset_spr_idx got=%0d exp=0", spr_idx); end
        total++; if (color !== 32'd0) begin bad++; $display("FAIL reset_color got=%0d exp=0", color); end
        Reset = 1'b0;
        for (int x = 0; x < 640; x++) begin
            DrawX = 10'(x);
            @(posedge Clk); #1;
            total++;
            if (color !== 32'd0) begin bad++; $display("FAIL reset_sweep x=%0d got=%0d exp=0", x, color); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_sweep_busy got=%0d exp=0", busy); end
    endtask

    task automatic test_single();
        int xs [5] = '{99, 100, 110, 119, 120};
        int ex [5] = '{0, 2, 2, 2, 0};
        set_slot(0, 1'b1, 10'd100, 10'd50, 10'd20, 10'd10, 32'd2);
        line_start = 1'b1; next_y = 10'd55;
        @(posedge Clk); #1;
        line_start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL scan_busy0 got=%0d exp=1", busy); end
        total++; if (spr_req !== 1'b1) begin bad++; $display("FAIL scan_req0 got=%0d exp=1", spr_req); end
        total++; if (spr_idx !== 3'd0) begin bad++; $display("FAIL scan_idx0 got=%0d exp=0", spr_idx); end
        for (int k = 1; k < 8; k++) begin
            @(posedge Clk); #1;
            total++;
            if (spr_req !== 1'b1 || spr_idx !== 3'(k)) begin
                bad++; $display("FAIL scan_issue k=%0d got req=%0d idx=%0d exp req=1 idx=%0d", k, spr_req, spr_idx, k);
            end
        end
        @(posedge Clk); #1;
        total++; if (spr_req !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL scan_last got req=%0d busy=%0d exp req=0 busy=1", spr_req, busy);
        end
        @(posedge Clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL scan_done_busy got=%0d exp=0", busy); end
        for (int i = 0; i < 5; i++) begin
            DrawX = 10'(xs[i]);
            @(posedge Clk); #1;
            total++;
            if (color !== 32'(ex[i])) begin bad++; $display("FAIL single x=%0d got=%0d exp=%0d", xs[i], color, ex[i]); end
        end
    endtask

    task automatic test_priority();
        int xs [5] = '{115, 125, 129, 130, 105};
        int ex [5] = '{2, 3, 3, 0, 2};
        set_slot(1, 1'b1, 10'd110, 10'd50, 10'd20, 10'd10, 32'd3);
        do_scan(10'd55);
        for (int i = 0; i < 5; i++) begin
            DrawX = 10'(xs[i]);
            @(posedge Clk); #1;
            total++;
            if (color !== 32'(ex[i])) begin bad++; $display("FAIL priority x=%0d got=%0d exp=%0d", xs[i], color, ex[i]); end
        end
    endtask

    task automatic test_vertical();
        int ys [4] = '{60, 50, 49, 59};
        int e100 [4] = '{0, 2, 0, 2};
        int e125 [4] = '{0, 3, 0, 3};
        for (int i = 0; i < 4; i++) begin
            do_scan(10'(ys[i]));
            DrawX = 10'd100;
            @(posedge Clk); #1;
            total++;
            if (color !== 32'(e100[i])) begin bad++; $display("FAIL vert y=%0d x=100 got=%0d exp=%0d", ys[i], color, e100[i]); end
            DrawX = 10'd125;
            @(posedge Clk); #1;
            total++;
            if (color !== 32'(e125[i])) begin bad++; $display("FAIL vert y=%0d x=125 got=%0d exp=%0d", ys[i], color, e125[i]); end
        end
    endtask

    task automatic test_edge();
        int xa [7] = '{629, 630, 639, 649, 650, 0, 300};
        int ea [7] = '{0, 5, 5, 5, 0, 0, 0};
        int xb [3] = '{0, 639, 640};
        int eb [3] = '{6, 6, 0};
        set_slot(0, 1'b0, 10'd100, 10'd50, 10'd20, 10'd10, 32'd2);
        set_slot(1, 1'b0, 10'd110, 10'd50, 10'd20, 10'd10, 32'd3);
        set_slot(2, 1'b1, 10'd630, 10'd0, 10'd20, 10'd100, 32'd5);
        set_slot(3, 1'b1, 10'd0, 10'd1020, 10'd640, 10'd10, 32'd6);
        do_scan(10'd5);
        for (int i = 0; i < 7; i++) begin
            DrawX = 10'(xa[i]);
            @(posedge Clk); #1;
            total++;
            if (color !== 32'(ea[i])) begin bad++; $display("FAIL edge_y5 x=%0d got=%0d exp=%0d", xa[i], color, ea[i]); end
        end
        do_scan(10'd1019);
        DrawX = 10'd0;
        @(posedge Clk); #1;
        total++;
        if (color !== 32'd0) begin bad++; $display("FAIL edge_y1019 got=%0d exp=0", color); end
        do_scan(10'd1023);
        for (int i = 0; i < 3; i++) begin
            DrawX = 10'(xb[i]);
            @(posedge Clk); #1;
            total++;
            if (color !== 32'(eb[i])) begin bad++; $display("FAIL edge_y1023 x=%0d got=%0d exp=%0d", xb[i], color, eb[i]); end
        end
    endtask

    task automatic test_overrun();
        int exp_c;
        logic exp_b, exp_o;
        // active spans: slot 3 only (line 1023), so column 0 shows 6
        DrawX = 10'd0;
        @(posedge Clk); #1;
        line_start = 1'b1; next_y = 10'd55;
        for (int c = 0; c <= 14; c++) begin
            @(posedge Clk); #1;
            line_start = (c == 3);
            if (c == 3) next_y = 10'd5;
            exp_b = (c <= 12);
            exp_o = (c >= 4);
            exp_c = (c <= 13) ? 6 : 0;
            total++;
            if (busy !== exp_b) begin bad++; $display("FAIL ovr_busy c=%0d got=%0d exp=%0d", c, busy, exp_b); end
            total++;
            if (overrun !== exp_o) begin bad++; $display("FAIL ovr_flag c=%0d got=%0d exp=%0d", c, overrun, exp_o); end
            total++;
            if (color !== 32'(exp_c)) begin bad++; $display("FAIL ovr_color c=%0d got=%0d exp=%0d", c, color, exp_c); end
        end
        DrawX = 10'd630;
        @(posedge Clk); #1;
        total++; if (color !== 32'd5) begin bad++; $display("FAIL ovr_newline got=%0d exp=5", color); end
        do_scan(10'd5);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%0d exp=1", overrun); end
    endtask

    task automatic test_reset_midscan();
        line_start = 1'b1; next_y = 10'd5;
        @(posedge Clk); #1;
        line_start = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        total++; if (busy !== 1'b0 || spr_req !== 1'b0 || spr_idx !== 3'd0) begin
            bad++; $display("FAIL midreset_ctl got busy=%0d req=%0d idx=%0d exp 0 0 0", busy, spr_req, spr_idx);
        end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL midreset_overrun got=%0d exp=0", overrun); end
        DrawX = 10'd630;
        @(posedge Clk); #1;
        total++; if (color !== 32'd0) begin bad++; $display("FAIL midreset_color got=%0d exp=0", color); end
        // Reset beats a simultaneous line_start
        Reset = 1'b1; line_start = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0; line_start = 1'b0;
        @(posedge Clk); #1;
        total++; if (busy !== 1'b0 || spr_req !== 1'b0) begin
            bad++; $display("FAIL reset_wins got busy=%0d req=%0d exp 0 0", busy, spr_req);
        end
        // back-to-back scans after recovery
        do_scan(10'd5);
        do_scan(10'd1023);
        DrawX = 10'd630;
        @(posedge Clk); #1;
        total++; if (color !== 32'd6) begin bad++; $display("FAIL b2b_color got=%0d exp=6", color); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%0d exp=0", overrun); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            set_slot(i, 1'b0, '0, '0, '0, '0, '0);
        end
        test_reset();
        test_single();
        test_priority();
        test_vertical();
        test_edge();
        test_overrun();
        test_reset_midscan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
